integral_window_stream: RTL and testbench
=========================================

Name: integral_window_stream

Overview:
- Parametrised successor to the binary integral-window buffer.
- Accepts a raster stream of multi-bit pixels under a valid/ready handshake and keeps WindowSize-1 lines in a line buffer.
- Maintains a WindowSize x WindowSize sliding window and emits its 2-D prefix-sum (integral) table for every fully-populated window position, tagged with coordinates and end-of-frame.
- Sits between the pixel source and the feature/classifier stages.

Parameters:
- ImageWidth, 64, pixels per line (>= WindowSize).
- ImageHeight, 48, lines per frame (>= WindowSize).
- WindowSize, 3, window side n (>= 2).
- PixelWidth, 8, bits per pixel P.
- Derived, not overridable:
  - SumWidth = P + $clog2(n*n).
  - XWidth = $clog2(ImageWidth).
  - YWidth = $clog2(ImageHeight).

Ports:
- Clock  in  1  single clock.
- Reset  in  1  synchronous, active-high reset.
- InValid  in  1  pixel offered.
- InReady  out  1  pixel accepted when InValid & InReady.
- InPixel  in  P  pixel value.
- InFrameStart  in  1  qualifies the first pixel of a frame.
- OutValid  out  1  integral table valid.
- OutReady  in  1  downstream accepts.
- IntegralPacked  out  SumWidth*n*n  entry k=n*y+x = sum of window pixels rows 0..y, cols 0..x (row 0 = oldest line, col 0 = oldest column).
- OutX  out  XWidth  column of the window's bottom-right pixel.
- OutY  out  YWidth  row of the window's bottom-right pixel.
- OutLast  out  1  last window of the frame.
- ResyncError  out  1  one-cycle pulse: InFrameStart seen mid-frame.

Behaviour:
- Reset values: OutValid=0, OutLast=0, ResyncError=0, IntegralPacked=0, OutX=0, OutY=0, state=IDLE, col=row=0. Line-buffer contents are not reset.
- InReady = !OutValid | OutReady. It is also 1 in IDLE. Output is a single register stage; no combinational path from InValid to OutValid.
- Accept = InValid & InReady.
- FSM, IDLE:
  - Accept with InFrameStart: store the pixel at (0,0), go to ACTIVE.
  - Accept without InFrameStart: pixel discarded.
- FSM, ACTIVE:
  - Each accept advances col; wrap at ImageWidth-1 to 0 and increment row.
  - After the accept at (ImageWidth-1, ImageHeight-1), return to IDLE.
  - Accept with InFrameStart: treat as (0,0) of a new frame and pulse ResyncError for 1 cycle. Window and line-buffer stale data are harmless because of the emission rule.
- Window shift: per accept, each window row shifts one column left.
  - The new rightmost column takes line-buffer outputs for rows 0..n-2 and InPixel for row n-1.
  - The line buffer is read-before-write at address col: it returns the pixel from the same column of the previous n-1 lines and stores InPixel.
- Emission: an accept at (col,row) with col>=n-1 and row>=n-1 loads the output register on the next edge.
  - Load values: integral table of the updated window, OutX=col, OutY=row, OutLast=(col==ImageWidth-1 & row==ImageHeight-1).
  - Latency is 1 cycle from the accepting edge.
- Integral computation: combinational from the window as row-wise prefix sums followed by column accumulation. All arithmetic is in SumWidth, unsigned, and cannot overflow (n*n*(2^P-1) < 2^SumWidth).
- Output hold: OutValid stays 1 and all Out* fields stay stable until OutValid & OutReady.
  - Handshake completing with no new emission: OutValid clears.
  - Handshake completing with a simultaneous new emission: OutValid stays 1 and new data loads.
- Windows never straddle lines, because emission requires col>=n-1 and the window is fully refilled each line.
- Windows per frame: (ImageWidth-n+1)*(ImageHeight-n+1).
- Reset mid-frame: next cycle OutValid=0, state IDLE. A pending output is dropped.

Decomposition:
- Shared package integral_pkg:
  - SumWidth/XWidth/YWidth derivation functions.
  - Packed-entry index function idx(y,x)=n*y+x.
  - Shared by downstream consumers.
- Sub-module pixel_line_buffer (params ImageWidth, WindowSize, PixelWidth):
  - (n-1) lines x ImageWidth x P storage.
  - Inputs: write-enable, address, data. Output: (n-1)*P read data, read-before-write.
- Everything else lives in the top module.

Test Plan:
All tests use n=3, ImageWidth=5, ImageHeight=4, P=8 (SumWidth=12), with OutReady=1 unless stated.
- Frame of all-1 pixels -> 6 outputs, the first 1 cycle after accepting (2,2). Entry k=3y+x equals (y+1)(x+1), entry 8 = 9. OutX/OutY sequence (2,2),(3,2),(4,2),(2,3),(3,3),(4,3). OutLast only on the 6th.
- Frame of all-255 -> entry 8 = 2295, entry 0 = 255, no wrap.
- Ramp pixel = col + 5*row -> window at (2,2): entry 2 = 3, entry 6 = 15, entry 8 = 54. Window at (4,3): entry 8 = 117.
- OutReady held low for 10 cycles after the first output -> InReady=0 and outputs stable throughout. On release, all 6 windows are delivered in order with none lost or duplicated.
- InFrameStart asserted at (3,1) mid-frame -> ResyncError pulses once, counters restart. Exactly 6 correct outputs follow from the new frame. Pixels sent in IDLE without InFrameStart produce nothing.
- Reset asserted while OutValid=1 mid-frame -> next cycle OutValid=0. A following clean frame produces the correct 6 outputs.

Source files
------------

// File: rtl/integral_pkg.sv
// Shared definitions for the integral-window stream and its downstream consumers:
// FSM state type, derived field widths and the packed-table entry index.
package integral_pkg;

  typedef enum logic [0:0] {
    StateIdle   = 1'b0,
    StateActive = 1'b1
  } streamState_e;

  function automatic int sumWidth(input int pixelWidth, input int windowSize);
    return pixelWidth + $clog2(windowSize * windowSize);
  endfunction

  function automatic int coordWidth(input int extent);
    return $clog2(extent);
  endfunction

  // Entry (row y, column x) of the window table, counted in SumWidth-wide slots.
  function automatic int idx(input int windowSize, input int y, input int x);
    return windowSize * y + x;
  endfunction

endpackage

// File: rtl/integral_window_stream_if.sv
// Pixel-in / integral-table-out stream bundle for integral_window_stream.
interface integral_window_stream_if
  import integral_pkg::*;
#(
  parameter int ImageWidth  = 64,
  parameter int ImageHeight = 48,
  parameter int WindowSize  = 3,
  parameter int PixelWidth  = 8
);
  localparam int SumWidth = sumWidth(PixelWidth, WindowSize);
  localparam int XWidth   = coordWidth(ImageWidth);
  localparam int YWidth   = coordWidth(ImageHeight);

  // Both channels use valid/ready: a beat transfers on a clock edge where valid and
  // ready are both high; once valid is raised the producer holds its data stable
  // until that edge, and valid never depends combinationally on ready.
  logic                                     InValid;
  logic                                     InReady;
  logic [PixelWidth-1:0]                    InPixel;
  logic                                     InFrameStart;
  logic                                     OutValid;
  logic                                     OutReady;
  logic [SumWidth*WindowSize*WindowSize-1:0] IntegralPacked;
  logic [XWidth-1:0]                        OutX;
  logic [YWidth-1:0]                        OutY;
  logic                                     OutLast;
  logic                                     ResyncError;

  modport master (
    output InValid, InPixel, InFrameStart, OutReady,
    input  InReady, OutValid, IntegralPacked, OutX, OutY, OutLast, ResyncError
  );

  modport slave (
    input  InValid, InPixel, InFrameStart, OutReady,
    output InReady, OutValid, IntegralPacked, OutX, OutY, OutLast, ResyncError
  );

endinterface

// File: rtl/pixel_line_buffer.sv
// Holds the previous WindowSize-1 lines; each write shifts one column up by a line
// and returns that column's old contents (oldest line in the lowest slice).
module pixel_line_buffer
  import integral_pkg::*;
#(
  parameter int ImageWidth = 64,
  parameter int WindowSize = 3,
  parameter int PixelWidth = 8
) (
  input  logic                                   Clock,
  input  logic                                   WriteEnable,
  input  logic [coordWidth(ImageWidth)-1:0]      Address,
  input  logic [PixelWidth-1:0]                  WriteData,
  output logic [(WindowSize-1)*PixelWidth-1:0]   ReadData
);
  localparam int Lines = WindowSize - 1;

  logic [PixelWidth-1:0] lineMem [Lines][ImageWidth];

  always_ff @(posedge Clock) begin
    if (WriteEnable) begin
      for (int k = 0; k < Lines - 1; k++) begin
        lineMem[k][Address] <= lineMem[k+1][Address];
      end
      lineMem[Lines-1][Address] <= WriteData;
    end
  end

  always_comb begin
    ReadData = '0;
    for (int k = 0; k < Lines; k++) begin
      ReadData[k*PixelWidth +: PixelWidth] = lineMem[k][Address];
    end
  end

endmodule

// File: rtl/integral_window_stream.sv
// Sliding WindowSize x WindowSize window over a raster pixel stream; emits the 2-D
// prefix-sum table of every fully populated window through one output register.
module integral_window_stream
  import integral_pkg::*;
#(
  parameter int ImageWidth  = 64,
  parameter int ImageHeight = 48,
  parameter int WindowSize  = 3,
  parameter int PixelWidth  = 8
) (
  input  logic                    Clock,
  input  logic                    Reset,
  integral_window_stream_if.slave stream,
  output streamState_e            DebugState
);
  localparam int N        = WindowSize;
  localparam int P        = PixelWidth;
  localparam int SumWidth = sumWidth(P, N);
  localparam int XWidth   = coordWidth(ImageWidth);
  localparam int YWidth   = coordWidth(ImageHeight);

  localparam logic [XWidth-1:0] LastCol      = XWidth'(ImageWidth - 1);
  localparam logic [YWidth-1:0] LastRow      = YWidth'(ImageHeight - 1);
  localparam logic [XWidth-1:0] FirstFullCol = XWidth'(N - 1);
  localparam logic [YWidth-1:0] FirstFullRow = YWidth'(N - 1);

  streamState_e          state, stateNext;
  logic [XWidth-1:0]     col, colNext, pixCol;
  logic [YWidth-1:0]     row, rowNext, pixRow;
  logic                  accept, storePixel, lastPixel, emit, resync;
  logic [(N-1)*P-1:0]    lbRead;
  logic [P-1:0]          win     [N][N];
  logic [P-1:0]          winNext [N][N];
  logic [SumWidth-1:0]   rowPrefix [N][N];
  logic [SumWidth*N*N-1:0] integralPacked;

  assign DebugState     = state;
  assign stream.InReady = (state == StateIdle) || !stream.OutValid || stream.OutReady;
  assign accept         = stream.InValid && stream.InReady;

  // A frame-start pixel always lands at (0,0), whether the FSM was idle or mid-frame.
  assign storePixel = accept && ((state == StateActive) || stream.InFrameStart);
  assign pixCol     = stream.InFrameStart ? '0 : col;
  assign pixRow     = stream.InFrameStart ? '0 : row;
  assign lastPixel  = (pixCol == LastCol) && (pixRow == LastRow);
  assign emit       = storePixel && (pixCol >= FirstFullCol) && (pixRow >= FirstFullRow);
  assign resync     = accept && stream.InFrameStart && (state == StateActive);

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state <= StateIdle;
      col   <= '0;
      row   <= '0;
    end else begin
      state <= stateNext;
      col   <= colNext;
      row   <= rowNext;
    end
  end

  always_comb begin
    stateNext = state;
    colNext   = col;
    rowNext   = row;
    if (storePixel) begin
      if (lastPixel) begin
        stateNext = StateIdle;
        colNext   = '0;
        rowNext   = '0;
      end else begin
        stateNext = StateActive;
        if (pixCol == LastCol) begin
          colNext = '0;
          rowNext = pixRow + 1'b1;
        end else begin
          colNext = pixCol + 1'b1;
          rowNext = pixRow;
        end
      end
    end
  end

  pixel_line_buffer #(
    .ImageWidth (ImageWidth),
    .WindowSize (WindowSize),
    .PixelWidth (PixelWidth)
  ) u_line_buffer (
    .Clock       (Clock),
    .WriteEnable (storePixel),
    .Address     (pixCol),
    .WriteData   (stream.InPixel),
    .ReadData    (lbRead)
  );

  always_comb begin
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        winNext[r][c] = win[r][c];
      end
    end
    if (storePixel) begin
      for (int r = 0; r < N; r++) begin
        for (int c = 0; c < N - 1; c++) begin
          winNext[r][c] = win[r][c+1];
        end
      end
      for (int r = 0; r < N - 1; r++) begin
        winNext[r][N-1] = lbRead[r*P +: P];
      end
      winNext[N-1][N-1] = stream.InPixel;
    end
  end

  always_ff @(posedge Clock) begin
    win <= winNext;
  end

  // Integral of the updated window: prefix along each row, then accumulate down columns.
  always_comb begin
    logic [SumWidth-1:0] rowAcc;
    logic [SumWidth-1:0] colAcc;
    rowAcc         = '0;
    colAcc         = '0;
    integralPacked = '0;
    for (int r = 0; r < N; r++) begin
      rowAcc = '0;
      for (int c = 0; c < N; c++) begin
        rowAcc          = rowAcc + SumWidth'(winNext[r][c]);
        rowPrefix[r][c] = rowAcc;
      end
    end
    for (int x = 0; x < N; x++) begin
      colAcc = '0;
      for (int y = 0; y < N; y++) begin
        colAcc = colAcc + rowPrefix[y][x];
        integralPacked[idx(N, y, x)*SumWidth +: SumWidth] = colAcc;
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      stream.OutValid       <= 1'b0;
      stream.OutLast        <= 1'b0;
      stream.ResyncError    <= 1'b0;
      stream.IntegralPacked <= '0;
      stream.OutX           <= '0;
      stream.OutY           <= '0;
    end else begin
      stream.ResyncError <= resync;
      if (emit) begin
        stream.OutValid       <= 1'b1;
        stream.IntegralPacked <= integralPacked;
        stream.OutX           <= pixCol;
        stream.OutY           <= pixRow;
        stream.OutLast        <= lastPixel;
      end else if (stream.OutReady) begin
        stream.OutValid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_integral_window_stream.sv
// Directed bench for integral_window_stream on a 5x4 image with a 3x3 window.
module tb_integral_window_stream;
  import integral_pkg::*;

  localparam int W    = 5;
  localparam int H    = 4;
  localparam int N    = 3;
  localparam int P    = 8;
  localparam int SW   = 12;
  localparam int PW   = SW * N * N;
  localparam int XW   = 3;
  localparam int YW   = 2;
  localparam int RecW = XW + YW + 1 + PW;
  localparam int NumWin  = (W - N + 1) * (H - N + 1);
  localparam int NumVecs = 22;

  // field: 0 = table entry, 1 = OutX, 2 = OutY, 3 = OutLast
  typedef struct {
    int pattern;
    int win;
    int field;
    int entry;
    int value;
  } vec_t;

  logic         Clock;
  logic         Reset;
  streamState_e debugState;

  integral_window_stream_if #(
    .ImageWidth(W), .ImageHeight(H), .WindowSize(N), .PixelWidth(P)
  ) bus ();

  integral_window_stream #(
    .ImageWidth(W), .ImageHeight(H), .WindowSize(N), .PixelWidth(P)
  ) dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .stream     (bus),
    .DebugState (debugState)
  );

  int total = 0;
  int bad   = 0;
  int resyncPulses = 0;
  logic [RecW-1:0] exp_q[$];
  logic [RecW-1:0] got_q[$];
  logic [RecW-1:0] capture [NumWin];
  vec_t vecs [NumVecs];

  // clock / reset
  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  // output monitor
  always @(negedge Clock) begin
    if (!Reset && bus.OutValid && bus.OutReady)
      got_q.push_back({bus.OutX, bus.OutY, bus.OutLast, bus.IntegralPacked});
    if (!Reset && bus.ResyncError)
      resyncPulses++;
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] pixelOf(input int pattern, input int c, input int r);
    case (pattern)
      0:       return 8'd1;
      1:       return 8'd255;
      2:       return 8'(c + 5 * r);
      3:       return 8'((c * 37 + r * 11 + 3) % 256);
      default: return 8'((200 + c * 17 + r * 29) % 256);
    endcase
  endfunction

  // Reference: each entry summed directly over its rectangle of source pixels.
  task automatic expectFrame(input int pattern);
    logic [PW-1:0] tbl;
    int s;
    for (int y = N - 1; y < H; y++) begin
      for (int x = N - 1; x < W; x++) begin
        tbl = '0;
        for (int ey = 0; ey < N; ey++) begin
          for (int ex = 0; ex < N; ex++) begin
            s = 0;
            for (int r = 0; r <= ey; r++)
              for (int c = 0; c <= ex; c++)
                s += int'(pixelOf(pattern, x - (N - 1) + c, y - (N - 1) + r));
            tbl[(N * ey + ex) * SW +: SW] = SW'(s);
          end
        end
        exp_q.push_back({XW'(x), YW'(y), (x == W - 1) && (y == H - 1), tbl});
      end
    end
  endtask

  // driver: entered and left at posedge+1
  task automatic sendPixel(input logic [7:0] pix, input logic fs);
    int budget;
    budget = 0;
    bus.InValid      = 1'b1;
    bus.InPixel      = pix;
    bus.InFrameStart = fs;
    @(negedge Clock);
    while (!bus.InReady && budget < 300) begin
      @(negedge Clock);
      budget++;
    end
    if (!bus.InReady) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: got InReady=0 for %0d cycles required 1", budget);
    end
    @(posedge Clock);
    #1;
    bus.InValid      = 1'b0;
    bus.InFrameStart = 1'b0;
  endtask

  task automatic sendFrame(input int pattern, input int firstIdx, input bit checkLatency);
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        if (r * W + c >= firstIdx) begin
          sendPixel(pixelOf(pattern, c, r), (r == 0) && (c == 0));
          if (checkLatency && r == 2 && c == 1)
            check("latency_before", bus.OutValid, 1'b0);
          if (checkLatency && r == 2 && c == 2) begin
            check("latency_valid", bus.OutValid, 1'b1);
            check("latency_x", bus.OutX, 2);
            check("latency_y", bus.OutY, 2);
          end
        end
      end
    end
  endtask

  // scoreboard drain: compares everything delivered against the expected queue
  task automatic checkFrame(input string name);
    int budget;
    int n;
    logic [RecW-1:0] e;
    logic [RecW-1:0] g;
    budget = 0;
    while (got_q.size() < exp_q.size() && budget < 100) begin
      @(posedge Clock);
      budget++;
    end
    repeat (4) @(posedge Clock);
    #1;
    check({name, "_count"}, 128'(got_q.size()), 128'(exp_q.size()));
    n = 0;
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      if (n < NumWin) capture[n] = g;
      check($sformatf("%s_win%0d", name, n), 128'(g), 128'(e));
      n++;
    end
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic applyTable(input int pattern);
    logic [RecW-1:0] rec;
    logic [PW-1:0]   tbl;
    int act;
    for (int i = 0; i < NumVecs; i++) begin
      if (vecs[i].pattern == pattern) begin
        rec = capture[vecs[i].win];
        tbl = rec[PW-1:0];
        case (vecs[i].field)
          0:       act = int'(tbl[vecs[i].entry * SW +: SW]);
          1:       act = int'(rec[RecW-1 -: XW]);
          2:       act = int'(rec[RecW-1-XW -: YW]);
          default: act = int'(rec[PW]);
        endcase
        check($sformatf("vec%0d_p%0d_w%0d", i, pattern, vecs[i].win), 128'(act), 128'(vecs[i].value));
      end
    end
  endtask

  initial begin
    logic [RecW-1:0] held;
    vecs = '{
      '{0, 0, 0, 0, 1}, '{0, 0, 0, 1, 2}, '{0, 0, 0, 2, 3},
      '{0, 0, 0, 3, 2}, '{0, 0, 0, 4, 4}, '{0, 0, 0, 5, 6},
      '{0, 0, 0, 6, 3}, '{0, 0, 0, 7, 6}, '{0, 0, 0, 8, 9},
      '{0, 5, 0, 8, 9},
      '{0, 1, 1, 0, 3}, '{0, 3, 1, 0, 2}, '{0, 3, 2, 0, 3},
      '{0, 4, 3, 0, 0}, '{0, 5, 3, 0, 1},
      '{1, 0, 0, 8, 2295}, '{1, 0, 0, 0, 255}, '{1, 3, 0, 8, 2295},
      '{2, 0, 0, 2, 3}, '{2, 0, 0, 6, 15}, '{2, 0, 0, 8, 54},
      '{2, 5, 0, 8, 117}
    };

    bus.InValid      = 1'b0;
    bus.InPixel      = '0;
    bus.InFrameStart = 1'b0;
    bus.OutReady     = 1'b1;
    Reset            = 1'b1;
    repeat (3) @(posedge Clock);
    #1;
    Reset = 1'b0;

    check("rst_out_valid", bus.OutValid, 1'b0);
    check("rst_out_last", bus.OutLast, 1'b0);
    check("rst_resync", bus.ResyncError, 1'b0);
    check("rst_integral", bus.IntegralPacked, '0);
    check("rst_out_x", bus.OutX, '0);
    check("rst_out_y", bus.OutY, '0);
    check("rst_state", debugState, StateIdle);
    check("rst_in_ready", bus.InReady, 1'b1);

    // table-driven frames
    for (int pat = 0; pat < 3; pat++) begin
      expectFrame(pat);
      sendFrame(pat, 0, pat == 0);
      checkFrame($sformatf("frame%0d", pat));
      applyTable(pat);
    end

    // downstream stall after the first output
    expectFrame(3);
    fork
      sendFrame(3, 0, 1'b0);
      begin
        int budget;
        budget = 0;
        while (!bus.OutValid && budget < 200) begin
          @(posedge Clock);
          #2;
          budget++;
        end
        check("stall_first_valid", bus.OutValid, 1'b1);
        bus.OutReady = 1'b0;
        held = {bus.OutX, bus.OutY, bus.OutLast, bus.IntegralPacked};
        for (int i = 0; i < 10; i++) begin
          @(negedge Clock);
          check($sformatf("stall_in_ready%0d", i), bus.InReady, 1'b0);
          check($sformatf("stall_hold%0d", i),
                128'({bus.OutValid, bus.OutX, bus.OutY, bus.OutLast, bus.IntegralPacked}),
                128'({1'b1, held}));
        end
        @(posedge Clock);
        #2;
        bus.OutReady = 1'b1;
      end
    join
    checkFrame("stall");

    // pixels without frame start while idle are dropped
    for (int i = 0; i < 20; i++)
      sendPixel(8'($urandom_range(0, 255)), 1'b0);
    checkFrame("idle_garbage");
    check("idle_state", debugState, StateIdle);

    // frame start arriving at (3,1) of an unfinished frame
    for (int i = 0; i < 8; i++)
      sendPixel(pixelOf(3, i % W, i / W), i == 0);
    check("pre_resync_pulses", resyncPulses, 0);
    expectFrame(4);
    sendPixel(pixelOf(4, 0, 0), 1'b1);
    check("resync_pulse", bus.ResyncError, 1'b1);
    sendFrame(4, 1, 1'b0);
    check("resync_low_after", bus.ResyncError, 1'b0);
    checkFrame("resync");
    check("resync_once", resyncPulses, 1);

    // reset while an output is pending
    bus.OutReady = 1'b0;
    for (int i = 0; i < 2 * W + 3; i++)
      sendPixel(pixelOf(1, i % W, i / W), i == 0);
    check("prereset_valid", bus.OutValid, 1'b1);
    Reset = 1'b1;
    @(posedge Clock);
    #1;
    check("midreset_valid", bus.OutValid, 1'b0);
    check("midreset_state", debugState, StateIdle);
    Reset        = 1'b0;
    bus.OutReady = 1'b1;
    expectFrame(2);
    sendFrame(2, 0, 1'b0);
    checkFrame("post_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
